dff_stimulus_debouncer: RTL and testbench
=========================================

Name: dff_stimulus_debouncer

Overview:
- Input-conditioning stage directly upstream of the D flip-flop circuit.
- Takes a raw D-data switch and a raw clock push-button, both asynchronous and bouncy, and synchronises and debounces each one.
- Drives a clean D level and a single-cycle clock pulse into the flip-flop stage, plus a wrapping count of accepted clock events for LED display.

Parameters:
- DEBOUNCE_CYCLES, 16: number of consecutive synchronised samples that must differ from the current stable level before that level flips. Legal range 1..31; 0 is illegal.
- CNT_W, 5: width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- EVT_W, 8: width of the accepted-event counter.

Ports:
- input_clk_0  in  1  system clock; all state changes on its rising edge.
- input_rst_0  in  1  synchronous, active-high reset.
- input_switch_d_0  in  1  raw D switch; asynchronous, may bounce.
- input_button_clk_0  in  1  raw clock push-button; asynchronous, may bounce.
- output_d_0  out  1  debounced D level.
- output_clk_level_0  out  1  debounced button level.
- output_clk_pulse_0  out  1  one-cycle pulse on each debounced button 0->1 transition.
- output_busy_0  out  1  high while either channel is in VERIFY.
- output_event_count_0  out  EVT_W  number of accepted clock pulses, modulo 2^EVT_W.

Behaviour:
- Interface: one clock, input_clk_0. Reset input_rst_0 is synchronous and active-high, sampled only on the input_clk_0 rising edge, and dominates all other logic.
- Reset values:
  - both synchroniser stages 0
  - stable levels 0 (output_d_0 = 0, output_clk_level_0 = 0)
  - both FSMs in STABLE, both counters 0
  - output_clk_pulse_0 = 0, output_busy_0 = 0, output_event_count_0 = 0
- Each channel (D, CLK) is an identical, independent instance:
  - 2-FF synchroniser: sync1 <= raw, sync2 <= sync1.
  - FSM with states STABLE and VERIFY, a CNT_W-bit counter, and a registered stable level.
- STABLE state:
  - sync2 == stable: remain in STABLE, cnt = 0.
  - sync2 != stable and DEBOUNCE_CYCLES == 1: stable <= sync2 on this edge; remain in STABLE.
  - sync2 != stable otherwise: go to VERIFY with cnt <= 1.
- VERIFY state:
  - sync2 == stable (glitch): return to STABLE, cnt <= 0, stable unchanged.
  - sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, go to STABLE, cnt <= 0.
  - sync2 != stable otherwise: cnt <= cnt+1.
- Latency: the raw input changes and then holds; the first rising edge that samples the new value is edge 1. The stable output updates on edge DEBOUNCE_CYCLES+2 (edge 18 at the default).
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES synchronised samples never changes the output. Any return of sync2 to the stable level restarts the count from zero.
- output_clk_pulse_0 (registered):
  - high for exactly the one cycle following the edge on which CLK stable goes 0->1
  - never asserted on a 1->0 transition
  - never asserted for the D channel
- output_event_count_0: increments on the same edge that sets output_clk_pulse_0. Wraps from 2^EVT_W-1 to 0 with no flag.
- output_busy_0: registered OR of (D FSM == VERIFY) and (CLK FSM == VERIFY).
- Simultaneous events: both channels transitioning on the same edge are handled independently. The D level and the clock pulse may change in the same cycle. Downstream, the flip-flop stage captures the D value present before that edge, so the bench checks ordering only via the flip-flop's own latching.
- Reset mid-operation: any in-progress VERIFY is aborted and outputs return to reset values on that edge. If a raw input is held at 1 through reset, its stable level rises DEBOUNCE_CYCLES+2 edges after the first edge with input_rst_0 = 0. For the CLK channel this produces one pulse and count = 1.
- Counters never exceed DEBOUNCE_CYCLES-1. There are no illegal FSM states; the 1-bit encoding covers both states.

Test Plan:
1. Reset, then input_button_clk_0 0->1 held → output_clk_level_0 rises on edge 18. output_clk_pulse_0 is high for exactly 1 cycle. output_event_count_0 = 1. output_busy_0 high for edges 3..17 and low after.
2. input_switch_d_0 glitch 1 for 10 cycles, then 0 (DEBOUNCE_CYCLES=16) → output_d_0 stays 0. Busy asserts, then drops. Count unchanged at 0.
3. Button bounce pattern 1,0,1,0 at 3-cycle intervals, then held 1 → exactly one pulse. The level rises 18 edges after the final 0->1 raw transition. Count = 1.
4. Button pressed and released 256 times, each phase held ≥20 cycles → 256 pulses. output_event_count_0 wraps 255->0 and reads 0 at the end. No pulses on releases.
5. Button held 1, input_rst_0 asserted for 1 cycle at cnt=8 → outputs read 0 after the reset edge. The level rises again on edge 18 counted from the first non-reset edge. Count = 1.
6. DEBOUNCE_CYCLES=1 build: a raw D switch 0->1 → output_d_0 rises on edge 3. A 1-cycle raw glitch propagates; this is required, since the minimum filter equals one sample.

Source files
------------

// File: rtl/dff_stimulus_debouncer_if.sv
// Bundles the raw switch/button inputs and the conditioned outputs of the
// stimulus debouncer into one port group.
interface dff_stimulus_debouncer_if #(
  parameter int unsigned EVT_W = 8
);
  logic             input_switch_d_0;
  logic             input_button_clk_0;
  logic             output_d_0;
  logic             output_clk_level_0;
  logic             output_clk_pulse_0;
  logic             output_busy_0;
  logic [EVT_W-1:0] output_event_count_0;

  modport master (
    output input_switch_d_0,
    output input_button_clk_0,
    input  output_d_0,
    input  output_clk_level_0,
    input  output_clk_pulse_0,
    input  output_busy_0,
    input  output_event_count_0
  );

  modport slave (
    input  input_switch_d_0,
    input  input_button_clk_0,
    output output_d_0,
    output output_clk_level_0,
    output output_clk_pulse_0,
    output output_busy_0,
    output output_event_count_0
  );
endinterface

// File: rtl/dff_stimulus_debouncer.sv
// Synchronises and debounces the raw D switch and clock button, producing a clean
// D level, a one-cycle clock pulse and a wrapping count of accepted clock events.
module dff_stimulus_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5,
  parameter int unsigned EVT_W           = 8
) (
  input logic                     input_clk_0,
  input logic                     input_rst_0,
  dff_stimulus_debouncer_if.slave bus
);
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_VERIFY = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel 0 is the D switch, channel 1 is the clock button.
  logic [1:0]       raw_s;
  logic [1:0]       stable_s;
  logic [1:0]       verify_next_s;
  logic             clk_rise_s;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic [EVT_W-1:0] evt_q, evt_d;

  assign raw_s = {bus.input_button_clk_0, bus.input_switch_d_0};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce FSM next-state: a level flips only after an unbroken run of differing samples
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      case (state_q)
        ST_STABLE: begin
          if (sync2_q == stable_q) begin
            cnt_d = CNT_ZERO;
          end else if (DEBOUNCE_CYCLES == 1) begin
            stable_d = sync2_q;
            cnt_d    = CNT_ZERO;
          end else begin
            state_d = ST_VERIFY;
            cnt_d   = CNT_ONE;
          end
        end
        ST_VERIFY: begin
          if (sync2_q == stable_q) begin
            state_d = ST_STABLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            state_d  = ST_STABLE;
            cnt_d    = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // Synchroniser, FSM state, counter and stable level registers
    always_ff @(posedge input_clk_0) begin
      if (input_rst_0) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        state_q  <= ST_STABLE;
        cnt_q    <= CNT_ZERO;
      end else begin
        sync1_q  <= raw_s[ch];
        sync2_q  <= sync1_q;
        stable_q <= stable_d;
        state_q  <= state_d;
        cnt_q    <= cnt_d;
      end
    end

    assign stable_s[ch]      = stable_q;
    assign verify_next_s[ch] = (state_d == ST_VERIFY);
  end

  assign clk_rise_s = g_chan[1].stable_d & ~g_chan[1].stable_q;

  // Pulse, event count and busy are computed from the same edge the levels change on
  always_comb begin
    pulse_d = clk_rise_s;
    busy_d  = |verify_next_s;
    if (clk_rise_s) begin
      evt_d = evt_q + EVT_W'(1);
    end else begin
      evt_d = evt_q;
    end
  end

  // Output register stage
  always_ff @(posedge input_clk_0) begin
    if (input_rst_0) begin
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      evt_q   <= EVT_W'(0);
    end else begin
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.output_d_0           = stable_s[0];
  assign bus.output_clk_level_0   = stable_s[1];
  assign bus.output_clk_pulse_0   = pulse_q;
  assign bus.output_busy_0        = busy_q;
  assign bus.output_event_count_0 = evt_q;
endmodule

// File: tb/tb_dff_stimulus_debouncer.sv
// Bench for dff_stimulus_debouncer: default build plus a DEBOUNCE_CYCLES=1 build,
// with a queue of expected event counts matched against each observed clock pulse.
module tb_dff_stimulus_debouncer;
  localparam int unsigned EVT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [EVT_W-1:0] exp_q [$];
  logic [EVT_W-1:0] exp_val;

  dff_stimulus_debouncer_if #(.EVT_W(EVT_W)) ifc ();
  dff_stimulus_debouncer_if #(.EVT_W(EVT_W)) ifc1 ();

  dff_stimulus_debouncer #(.DEBOUNCE_CYCLES(16), .CNT_W(5), .EVT_W(EVT_W)) dut (
    .input_clk_0 (clk),
    .input_rst_0 (rst),
    .bus         (ifc)
  );

  dff_stimulus_debouncer #(.DEBOUNCE_CYCLES(1), .CNT_W(5), .EVT_W(EVT_W)) dut1 (
    .input_clk_0 (clk),
    .input_rst_0 (rst),
    .bus         (ifc1)
  );

  always #5 clk = ~clk;

  // Every pulse seen must consume the next expected event count
  always @(negedge clk) begin
    if (!rst && ifc.output_clk_pulse_0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: pulse seen with count %0d, required no pulse", ifc.output_event_count_0);
      end else begin
        exp_val = exp_q.pop_front();
        if (ifc.output_event_count_0 !== exp_val) begin
          errors++;
          $display("FAIL pulse_count: got %0d required %0d", ifc.output_event_count_0, exp_val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifc.input_switch_d_0    = 1'b0;
    ifc.input_button_clk_0  = 1'b0;
    ifc1.input_switch_d_0   = 1'b0;
    ifc1.input_button_clk_0 = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ifc.input_switch_d_0    = 1'b1;
    ifc.input_button_clk_0  = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    checks += 6;
    if (ifc.output_d_0 !== 1'b0) begin errors++; $display("FAIL rst_d: got %b required 0", ifc.output_d_0); end
    if (ifc.output_clk_level_0 !== 1'b0) begin errors++; $display("FAIL rst_level: got %b required 0", ifc.output_clk_level_0); end
    if (ifc.output_clk_pulse_0 !== 1'b0) begin errors++; $display("FAIL rst_pulse: got %b required 0", ifc.output_clk_pulse_0); end
    if (ifc.output_busy_0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", ifc.output_busy_0); end
    if (ifc.output_event_count_0 !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", ifc.output_event_count_0); end
    if (ifc1.output_d_0 !== 1'b0) begin errors++; $display("FAIL rst_d1: got %b required 0", ifc1.output_d_0); end
    do_reset();
  endtask

  task automatic test_press();
    do_reset();
    exp_q.push_back(8'd1);
    ifc.input_button_clk_0 = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      tick();
      checks += 2;
      if (ifc.output_clk_level_0 !== (e >= 18)) begin
        errors++; $display("FAIL press_level: edge %0d got %b required %b", e, ifc.output_clk_level_0, (e >= 18));
      end
      if (ifc.output_busy_0 !== (e >= 3 && e <= 17)) begin
        errors++; $display("FAIL press_busy: edge %0d got %b required %b", e, ifc.output_busy_0, (e >= 3 && e <= 17));
      end
    end
    checks += 2;
    if (ifc.output_event_count_0 !== 8'd1) begin errors++; $display("FAIL press_count: got %0d required 1", ifc.output_event_count_0); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL press_missing_pulse: got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_d_glitch();
    do_reset();
    ifc.input_switch_d_0 = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 10) ifc.input_switch_d_0 = 1'b0;
      checks += 2;
      if (ifc.output_d_0 !== 1'b0) begin
        errors++; $display("FAIL glitch_d: edge %0d got %b required 0", e, ifc.output_d_0);
      end
      if (ifc.output_busy_0 !== (e >= 3 && e <= 12)) begin
        errors++; $display("FAIL glitch_busy: edge %0d got %b required %b", e, ifc.output_busy_0, (e >= 3 && e <= 12));
      end
    end
    checks++;
    if (ifc.output_event_count_0 !== 8'd0) begin errors++; $display("FAIL glitch_count: got %0d required 0", ifc.output_event_count_0); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int p = 0; p < 4; p++) begin
      ifc.input_button_clk_0 = (p % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (ifc.output_clk_level_0 !== 1'b0) begin
          errors++; $display("FAIL bounce_early_level: phase %0d got %b required 0", p, ifc.output_clk_level_0);
        end
      end
    end
    exp_q.push_back(8'd1);
    ifc.input_button_clk_0 = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick();
      checks++;
      if (ifc.output_clk_level_0 !== (e >= 18)) begin
        errors++; $display("FAIL bounce_level: edge %0d got %b required %b", e, ifc.output_clk_level_0, (e >= 18));
      end
    end
    checks += 2;
    if (ifc.output_event_count_0 !== 8'd1) begin errors++; $display("FAIL bounce_count: got %0d required 1", ifc.output_event_count_0); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL bounce_missing_pulse: got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      n = (n + 1) % 256;
      exp_q.push_back(n[EVT_W-1:0]);
      ifc.input_button_clk_0 = 1'b1;
      repeat (20) tick();
      checks += 2;
      if (ifc.output_clk_level_0 !== 1'b1) begin errors++; $display("FAIL wrap_press_level: press %0d got %b required 1", i, ifc.output_clk_level_0); end
      if (ifc.output_event_count_0 !== n[EVT_W-1:0]) begin errors++; $display("FAIL wrap_count: press %0d got %0d required %0d", i, ifc.output_event_count_0, n); end
      ifc.input_button_clk_0 = 1'b0;
      repeat (20) tick();
      checks++;
      if (ifc.output_clk_level_0 !== 1'b0) begin errors++; $display("FAIL wrap_release_level: press %0d got %b required 0", i, ifc.output_clk_level_0); end
    end
    checks += 2;
    if (ifc.output_event_count_0 !== 8'd0) begin errors++; $display("FAIL wrap_final_count: got %0d required 0", ifc.output_event_count_0); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing_pulse: got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ifc.input_button_clk_0 = 1'b1;
    repeat (10) tick();
    checks++;
    if (ifc.output_busy_0 !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b required 1", ifc.output_busy_0); end
    rst = 1'b1;
    tick();
    checks += 4;
    if (ifc.output_clk_level_0 !== 1'b0) begin errors++; $display("FAIL mid_rst_level: got %b required 0", ifc.output_clk_level_0); end
    if (ifc.output_busy_0 !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b required 0", ifc.output_busy_0); end
    if (ifc.output_clk_pulse_0 !== 1'b0) begin errors++; $display("FAIL mid_rst_pulse: got %b required 0", ifc.output_clk_pulse_0); end
    if (ifc.output_event_count_0 !== 8'd0) begin errors++; $display("FAIL mid_rst_count: got %0d required 0", ifc.output_event_count_0); end
    rst = 1'b0;
    exp_q.push_back(8'd1);
    for (int e = 1; e <= 22; e++) begin
      tick();
      checks += 2;
      if (ifc.output_clk_level_0 !== (e >= 18)) begin
        errors++; $display("FAIL mid_level: edge %0d got %b required %b", e, ifc.output_clk_level_0, (e >= 18));
      end
      if (ifc.output_busy_0 !== (e >= 3 && e <= 17)) begin
        errors++; $display("FAIL mid_busy: edge %0d got %b required %b", e, ifc.output_busy_0, (e >= 3 && e <= 17));
      end
    end
    checks += 2;
    if (ifc.output_event_count_0 !== 8'd1) begin errors++; $display("FAIL mid_count: got %0d required 1", ifc.output_event_count_0); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_missing_pulse: got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_single_cycle();
    logic [4:0] exp_pat;
    exp_pat = 5'b11011;
    do_reset();
    ifc1.input_switch_d_0 = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks += 2;
      if (ifc1.output_d_0 !== (e >= 3)) begin
        errors++; $display("FAIL one_rise_d: edge %0d got %b required %b", e, ifc1.output_d_0, (e >= 3));
      end
      if (ifc1.output_busy_0 !== 1'b0) begin
        errors++; $display("FAIL one_busy: edge %0d got %b required 0", e, ifc1.output_busy_0);
      end
    end
    ifc1.input_switch_d_0 = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 1) ifc1.input_switch_d_0 = 1'b1;
      checks++;
      if (ifc1.output_d_0 !== exp_pat[e-1]) begin
        errors++; $display("FAIL one_glitch_d: edge %0d got %b required %b", e, ifc1.output_d_0, exp_pat[e-1]);
      end
    end
  endtask

  initial begin
    ifc.input_switch_d_0    = 1'b0;
    ifc.input_button_clk_0  = 1'b0;
    ifc1.input_switch_d_0   = 1'b0;
    ifc1.input_button_clk_0 = 1'b0;
    test_reset();
    test_press();
    test_d_glitch();
    test_bounce();
    test_wrap();
    test_reset_mid();
    test_single_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
